// File: rtl/dpsk_word_link.sv
// DPSK word transceiver: serialises a word MSB first onto a differentially phased
// square-wave carrier and recovers it with a per-symbol correlating demodulator.
module dpsk_word_link #(
    parameter int WORD_W   = 8,
    parameter int SPS      = 4,
    parameter int MODE     = 0,
    parameter int INIT_REF = 0,
    parameter int LOOPBACK = 1
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] data_in,
    input  logic              rx_in,
    output logic              ready,
    output logic              tx_wave,
    output logic              demodulated,
    output logic              neg_demodulated,
    output logic              bit_valid,
    output logic              new_word,
    output logic [WORD_W-1:0] data_out
);

    localparam int SC_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int AG_W = $clog2(SPS + 1);

    typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;

    state_t            state, state_nx;
    logic [SC_W-1:0]   sc;
    logic [BC_W-1:0]   bc;
    logic [AG_W-1:0]   agree, agree_nx;
    logic [WORD_W-1:0] tx_sr, asm_sr;
    logic              phase, prev_hat, phase_hat, dbit;
    logic              carrier, r, sym_end, last_bit;

    // Majority decision over one symbol; a tie keeps the previous phase estimate.
    function automatic logic decide_phase(input logic [AG_W-1:0] cnt, input logic prev);
        logic [AG_W:0] twice;
        twice = {cnt, 1'b0};
        if (twice > (AG_W+1)'(SPS))      return 1'b0;
        else if (twice < (AG_W+1)'(SPS)) return 1'b1;
        else                             return prev;
    endfunction

    function automatic logic enc_flip(input logic b);
        return (MODE == 0) ? b : ~b;
    endfunction

    assign sym_end  = (sc == SC_W'(SPS - 1));
    assign last_bit = (bc == BC_W'(WORD_W - 1));

    always_ff @(posedge clk1) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = PRE;
            PRE:     if (sym_end) state_nx = DATA;
            DATA:    if (sym_end && last_bit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready   = (state == IDLE);
        carrier = (sc < SC_W'(SPS / 2));
        tx_wave = (state != IDLE) & (carrier ^ phase);
    end

    // Demodulator sample path: the final sample of a symbol is folded in at the decision edge.
    always_comb begin
        r         = (LOOPBACK != 0) ? tx_wave : rx_in;
        agree_nx  = agree + AG_W'(r == carrier);
        phase_hat = decide_phase(agree_nx, prev_hat);
        dbit      = (MODE == 0) ? (phase_hat ^ prev_hat) : ~(phase_hat ^ prev_hat);
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            sc              <= '0;
            bc              <= '0;
            agree           <= '0;
            tx_sr           <= '0;
            asm_sr          <= '0;
            phase           <= 1'b0;
            prev_hat        <= 1'b0;
            demodulated     <= 1'b0;
            neg_demodulated <= 1'b1;
            bit_valid       <= 1'b0;
            new_word        <= 1'b0;
            data_out        <= '0;
        end else begin
            bit_valid <= 1'b0;
            new_word  <= 1'b0;
            if (state == IDLE) begin
                if (load) begin
                    tx_sr <= data_in;
                    phase <= (INIT_REF != 0);
                    sc    <= '0;
                    bc    <= '0;
                    agree <= '0;
                end
            end else if (!sym_end) begin
                sc    <= sc + SC_W'(1);
                agree <= agree_nx;
            end else begin
                sc       <= '0;
                agree    <= '0;
                prev_hat <= phase_hat;
                if (state == DATA) begin
                    bit_valid       <= 1'b1;
                    demodulated     <= dbit;
                    neg_demodulated <= ~dbit;
                    asm_sr          <= {asm_sr[WORD_W-2:0], dbit};
                end
                // Next data symbol takes its phase from the next MSB of the shift register.
                if (state == PRE || !last_bit) begin
                    phase <= phase ^ enc_flip(tx_sr[WORD_W-1]);
                    tx_sr <= {tx_sr[WORD_W-2:0], 1'b0};
                end
                if (state == DATA) begin
                    if (last_bit) begin
                        data_out <= {asm_sr[WORD_W-2:0], dbit};
                        new_word <= 1'b1;
                        bc       <= '0;
                    end else begin
                        bc <= bc + BC_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dpsk_word_link.sv
// Directed bench for dpsk_word_link: loopback, MODE=1 and external rx instances.
module tb_dpsk_word_link;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic       rst = 1'b1;
    logic       load0 = 0, load1 = 0, load2 = 0;
    logic [7:0] d0 = 0, d1 = 0, d2 = 0;
    logic       rx0 = 0, inv = 0;
    logic       rdy0, tx0, dm0, ndm0, bv0, nw0;
    logic       rdy1, tx1, dm1, ndm1, bv1, nw1;
    logic       rdy2, tx2, dm2, ndm2, bv2, nw2;
    logic [7:0] do0, do1, do2;
    wire        rx2 = tx2 ^ inv;

    int checks = 0, errors = 0;

    dpsk_word_link #(.WORD_W(8), .SPS(4), .MODE(0), .INIT_REF(0), .LOOPBACK(1)) dut0 (
        .clk1(clk1), .rst(rst), .load(load0), .data_in(d0), .rx_in(rx0), .ready(rdy0),
        .tx_wave(tx0), .demodulated(dm0), .neg_demodulated(ndm0), .bit_valid(bv0),
        .new_word(nw0), .data_out(do0));
    dpsk_word_link #(.WORD_W(8), .SPS(4), .MODE(1), .INIT_REF(0), .LOOPBACK(1)) dut1 (
        .clk1(clk1), .rst(rst), .load(load1), .data_in(d1), .rx_in(rx0), .ready(rdy1),
        .tx_wave(tx1), .demodulated(dm1), .neg_demodulated(ndm1), .bit_valid(bv1),
        .new_word(nw1), .data_out(do1));
    dpsk_word_link #(.WORD_W(8), .SPS(4), .MODE(0), .INIT_REF(0), .LOOPBACK(0)) dut2 (
        .clk1(clk1), .rst(rst), .load(load2), .data_in(d2), .rx_in(rx2), .ready(rdy2),
        .tx_wave(tx2), .demodulated(dm2), .neg_demodulated(ndm2), .bit_valid(bv2),
        .new_word(nw2), .data_out(do2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic run1(input logic [7:0] d, output logic [15:0] txh, output int nwk);
        load1 = 1; d1 = d; step(); load1 = 0;
        nwk = -1; txh = '0;
        for (int k = 0; k <= 40; k++) begin
            if (k < 16) txh = {txh[14:0], tx1};
            if (nw1 && nwk < 0) nwk = k;
            step();
        end
    endtask

    task automatic run2(input logic [7:0] d, input int m, output int nwk);
        load2 = 1; d2 = d; step(); load2 = 0;
        nwk = -1;
        for (int k = 0; k <= 40; k++) begin
            inv = (m == 1 && (k % 4) == 2) || (m == 2 && (k % 4) >= 2);
            if (nw2 && nwk < 0) nwk = k;
            step();
        end
        inv = 0;
    endtask

    initial begin
        logic [7:0]  bits, tx8;
        logic [15:0] txh;
        int nbv, nwc, nwk, negbad, cnt;
        logic rdy_nw;

        step(); step(); rst = 0;
        chk("rst_ready", rdy0, 1); chk("rst_tx", tx0, 0); chk("rst_dm", dm0, 0);
        chk("rst_ndm", ndm0, 1); chk("rst_bv", bv0, 0); chk("rst_nw", nw0, 0);
        chk("rst_do", do0, 0);

        // Test 1: A5 in loopback
        load0 = 1; d0 = 8'hA5; step(); load0 = 0;
        bits = 0; tx8 = 0; nbv = 0; nwc = 0; nwk = -1; negbad = 0; rdy_nw = 0;
        for (int k = 0; k <= 36; k++) begin
            if (k < 8) tx8 = {tx8[6:0], tx0};
            if (bv0) begin bits = {bits[6:0], dm0}; nbv++; end
            if (nw0) begin nwc++; nwk = k; rdy_nw = rdy0; end
            if (ndm0 !== ~dm0) negbad++;
            if (k < 36) step();
        end
        chk("t1_tx_pre_bit0", tx8, 8'b1100_0011);
        chk("t1_bits", bits, 8'hA5); chk("t1_nbv", nbv, 8);
        chk("t1_nw_count", nwc, 1); chk("t1_nw_edge", nwk, 36);
        chk("t1_do", do0, 8'hA5); chk("t1_ready_at_nw", rdy_nw, 1);
        chk("t1_neg", negbad, 0);
        step(); step(); step();
        chk("t1_do_hold", do0, 8'hA5); chk("t1_dm_hold", dm0, 1); chk("t1_nw_drop", nw0, 0);

        // Test 2: load while busy is ignored
        load0 = 1; d0 = 8'hFF; step(); load0 = 0;
        nwc = 0; nwk = -1;
        for (int k = 0; k < 60; k++) begin
            if (nw0) begin nwc++; if (nwk < 0) nwk = k; end
            load0 = (k == 10); d0 = (k == 10) ? 8'h3C : 8'hFF;
            step();
        end
        load0 = 0;
        chk("t2_nw_count", nwc, 1); chk("t2_nw_edge", nwk, 36); chk("t2_do", do0, 8'hFF);

        // Test 6: back-to-back reload on first ready cycle
        load0 = 1; d0 = 8'h96; step(); load0 = 0;
        cnt = 0;
        while (!nw0 && cnt < 60) begin step(); cnt++; end
        chk("t6_first_nw_found", nw0, 1); chk("t6_first_do", do0, 8'h96);
        chk("t6_ready_at_nw", rdy0, 1);
        load0 = 1; d0 = 8'h4B; step(); load0 = 0;
        cnt = 1; negbad = 0;
        while (!nw0 && cnt < 60) begin
            if (ndm0 !== ~dm0) negbad++;
            step(); cnt++;
        end
        chk("t6_spacing", cnt, 37); chk("t6_do", do0, 8'h4B); chk("t6_neg", negbad, 0);

        // Test 5: reset during data symbol 4
        load0 = 1; d0 = 8'h5A; step(); load0 = 0;
        for (int k = 0; k < 17; k++) step();
        rst = 1; step(); rst = 0;
        chk("t5_ready", rdy0, 1); chk("t5_tx", tx0, 0); chk("t5_dm", dm0, 0);
        chk("t5_ndm", ndm0, 1); chk("t5_bv", bv0, 0); chk("t5_nw", nw0, 0);
        chk("t5_do", do0, 0);
        nwc = 0;
        for (int k = 0; k < 40; k++) begin if (nw0) nwc++; step(); end
        chk("t5_no_nw", nwc, 0);
        load0 = 1; d0 = 8'h81; step(); load0 = 0;
        cnt = 0;
        while (!nw0 && cnt < 60) begin step(); cnt++; end
        chk("t5_after_edge", cnt, 36); chk("t5_after_do", do0, 8'h81);

        // Test 3: MODE=1
        run1(8'h00, txh, nwk);
        chk("t3_tx_00", txh, 16'hC3C3); chk("t3_nw_00", nwk, 36); chk("t3_do_00", do1, 8'h00);
        run1(8'hFF, txh, nwk);
        chk("t3_tx_ff", txh, 16'hCCCC); chk("t3_nw_ff", nwk, 36); chk("t3_do_ff", do1, 8'hFF);

        // Test 4: external rx with corrupted samples
        run2(8'hC3, 1, nwk);
        chk("t4_one_err_nw", nwk, 36); chk("t4_one_err_do", do2, 8'hC3);
        run2(8'hC3, 2, nwk);
        chk("t4_tie_nw", nwk, 36); chk("t4_tie_do", do2, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
